// File: rtl/crc_pkg.sv
// Shared types and helpers for the streaming CRC engine: FSM encoding,
// well-known generator polynomials and a byte bit-reversal helper.
package crc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2
  } state_e;

  localparam logic [31:0] POLY_CRC32 = 32'h04c11db7;
  localparam logic [15:0] POLY_CCITT = 16'h1021;
  localparam logic [3:0]  POLY_CRC4  = 4'h3;

  function automatic logic [7:0] byte_reflect(input logic [7:0] b);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = b[7-i];
    return r;
  endfunction

endpackage

// File: rtl/crc_byte_update.sv
// Combinational advance of a C_GEN_WIDTH CRC register by one byte:
// optional byte reflection, then eight MSB-first shift/XOR steps.
module crc_byte_update
  import crc_pkg::*;
#(
  parameter int          C_GEN_WIDTH  = 32,
  parameter logic [31:0] C_GEN_SEQ    = POLY_CRC32,
  parameter bit          C_IN_REFLECT = 1'b1
) (
  input  logic [C_GEN_WIDTH-1:0] crc_in,
  input  logic [7:0]             data_byte,
  output logic [C_GEN_WIDTH-1:0] crc_out
);

  localparam logic [C_GEN_WIDTH-1:0] POLY = C_GEN_SEQ[C_GEN_WIDTH-1:0];

  always_comb begin
    logic [7:0]             b;
    logic [C_GEN_WIDTH-1:0] c;
    logic                   fb;
    b = C_IN_REFLECT ? byte_reflect(data_byte) : data_byte;
    c = crc_in;
    for (int i = 7; i >= 0; i--) begin
      fb = c[C_GEN_WIDTH-1] ^ b[i];
      c  = {c[C_GEN_WIDTH-2:0], 1'b0};
      if (fb) c = c ^ POLY;
    end
    crc_out = c;
  end

endmodule

// File: rtl/crc_stream_engine.sv
// Multi-lane streaming CRC generator/checker with sof/eof framing, keep mask on eof
// and a held valid/ready result port. Define CRC_CHECK_EN to build the residue check.
module crc_stream_engine
  import crc_pkg::*;
#(
  parameter int          C_DWIDTH      = 32,
  parameter int          C_GEN_WIDTH   = 32,
  parameter logic [31:0] C_GEN_SEQ     = 32'h04c11db7,
  parameter logic [31:0] C_INIT        = 32'hffffffff,
  parameter logic [31:0] C_XOR_OUT     = 32'hffffffff,
  parameter bit          C_IN_REFLECT  = 1'b1,
  parameter bit          C_OUT_REFLECT = 1'b1,
  parameter logic [31:0] C_RESIDUE     = 32'hc704dd7b,
  parameter int          C_LEN_WIDTH   = 16
) (
  input  logic                     I_clk,
  input  logic                     I_rst,
  input  logic [C_DWIDTH-1:0]      I_data,
  input  logic                     I_data_v,
  input  logic                     I_sof,
  input  logic                     I_eof,
  input  logic [C_DWIDTH/8-1:0]    I_keep,
  output logic                     O_ready,
  output logic [C_GEN_WIDTH-1:0]   O_crc,
  output logic [C_LEN_WIDTH-1:0]   O_len,
  output logic                     O_crc_v,
  input  logic                     I_crc_ready,
  output logic                     O_crc_ok,
  output logic                     O_frame_err
);

  localparam int NB = C_DWIDTH / 8;
  localparam int CW = $clog2(NB + 1);
  localparam int W  = C_GEN_WIDTH;
  localparam int LW = C_LEN_WIDTH;
  localparam logic [W-1:0] INIT = C_INIT[W-1:0];
  localparam logic [W-1:0] XOUT = C_XOR_OUT[W-1:0];

  state_e          state_q, state_d;
  logic [W-1:0]    crc_reg_q, crc_reg_d;
  logic [LW-1:0]   len_acc_q, len_acc_d;
  logic            ready_q, ready_d;
  logic            crc_v_q, crc_v_d;
  logic [W-1:0]    crc_q, crc_d;
  logic [LW-1:0]   len_q, len_d;
  logic            frame_err_q, frame_err_d;
`ifdef CRC_CHECK_EN
  localparam logic [W-1:0] RESIDUE = C_RESIDUE[W-1:0];
  logic            crc_ok_q, crc_ok_d;
`endif

  logic                 accept;
  logic                 restart;
  logic [NB-1:0]        keep_eff;
  logic [CW-1:0]        nbytes;
  logic [NB:0][W-1:0]   stage;
  logic [NB-1:0][W-1:0] upd;
  logic [W-1:0]         crc_next;
  logic [W-1:0]         crc_final;
  logic [LW:0]          len_sum;
  logic [LW-1:0]        len_next;

  assign accept  = I_data_v & ready_q;
  assign restart = (state_q == ST_IDLE) | I_sof;

  // Keep is honoured only on eof and only up to its first zero bit.
  always_comb begin
    logic run;
    run      = 1'b1;
    keep_eff = '0;
    nbytes   = '0;
    for (int i = 0; i < NB; i++) begin
      run         = run & (~I_eof | I_keep[i]);
      keep_eff[i] = run;
      nbytes      = nbytes + CW'(run);
    end
  end

  assign stage[0] = restart ? INIT : crc_reg_q;

  for (genvar g = 0; g < NB; g++) begin : g_lane
    crc_byte_update #(
      .C_GEN_WIDTH (W),
      .C_GEN_SEQ   (C_GEN_SEQ),
      .C_IN_REFLECT(C_IN_REFLECT)
    ) u_upd (
      .crc_in   (stage[g]),
      .data_byte(I_data[8*g +: 8]),
      .crc_out  (upd[g])
    );
    assign stage[g+1] = keep_eff[g] ? upd[g] : stage[g];
  end

  assign crc_next = stage[NB];
  assign len_sum  = {1'b0, (restart ? {LW{1'b0}} : len_acc_q)} + (LW+1)'(nbytes);
  assign len_next = len_sum[LW] ? {LW{1'b1}} : len_sum[LW-1:0];

  always_comb begin
    logic [W-1:0] r;
    r = crc_next;
    if (C_OUT_REFLECT) begin
      for (int i = 0; i < W; i++) r[i] = crc_next[W-1-i];
    end
    crc_final = r ^ XOUT;
  end

  always_comb begin
    state_d     = state_q;
    crc_reg_d   = crc_reg_q;
    len_acc_d   = len_acc_q;
    ready_d     = ready_q;
    crc_v_d     = crc_v_q;
    crc_d       = crc_q;
    len_d       = len_q;
    frame_err_d = 1'b0;
`ifdef CRC_CHECK_EN
    crc_ok_d    = crc_ok_q;
`endif
    case (state_q)
      ST_IDLE, ST_RUN: begin
        if (accept) begin
          // In IDLE a missing sof is the error; in RUN an extra sof is.
          frame_err_d = (state_q == ST_IDLE) ? ~I_sof : I_sof;
          if (state_q == ST_RUN || I_sof) begin
            crc_reg_d = crc_next;
            len_acc_d = len_next;
            state_d   = ST_RUN;
            if (I_eof) begin
              state_d = ST_HOLD;
              ready_d = 1'b0;
              crc_v_d = 1'b1;
              crc_d   = crc_final;
              len_d   = len_next;
`ifdef CRC_CHECK_EN
              crc_ok_d = (crc_next == RESIDUE);
`endif
            end
          end
        end
      end
      ST_HOLD: begin
        if (I_crc_ready) begin
          state_d = ST_IDLE;
          ready_d = 1'b1;
          crc_v_d = 1'b0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        ready_d = 1'b1;
        crc_v_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      state_q     <= ST_IDLE;
      crc_reg_q   <= '0;
      len_acc_q   <= '0;
      ready_q     <= 1'b1;
      crc_v_q     <= 1'b0;
      crc_q       <= '0;
      len_q       <= '0;
      frame_err_q <= 1'b0;
`ifdef CRC_CHECK_EN
      crc_ok_q    <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      crc_reg_q   <= crc_reg_d;
      len_acc_q   <= len_acc_d;
      ready_q     <= ready_d;
      crc_v_q     <= crc_v_d;
      crc_q       <= crc_d;
      len_q       <= len_d;
      frame_err_q <= frame_err_d;
`ifdef CRC_CHECK_EN
      crc_ok_q    <= crc_ok_d;
`endif
    end
  end

  assign O_ready     = ready_q;
  assign O_crc_v     = crc_v_q;
  assign O_crc       = crc_q;
  assign O_len       = len_q;
  assign O_frame_err = frame_err_q;
`ifdef CRC_CHECK_EN
  assign O_crc_ok    = crc_ok_q;
`else
  assign O_crc_ok    = 1'b0;
`endif

endmodule

// File: tb/tb_crc_stream_engine.sv
// Scoreboard bench for crc_stream_engine: a 32-bit CRC-32 instance and an 8-bit CCITT instance.
module tb_crc_stream_engine;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic [31:0] data = '0;
  logic        data_v = 1'b0, sof = 1'b0, eof = 1'b0, crc_ready = 1'b0;
  logic [3:0]  keep = '0;
  logic        ready, crc_v, crc_ok, frame_err;
  logic [31:0] crc;
  logic [15:0] len;

  logic [7:0]  d8_data = '0;
  logic        d8_v = 1'b0, d8_sof = 1'b0, d8_eof = 1'b0, d8_crc_ready = 1'b0;
  logic [0:0]  d8_keep = 1'b1;
  logic        d8_ready, d8_crc_v, d8_ok, d8_err;
  logic [15:0] d8_crc, d8_len;

  crc_stream_engine dut (
    .I_clk(clk), .I_rst(rst), .I_data(data), .I_data_v(data_v), .I_sof(sof), .I_eof(eof),
    .I_keep(keep), .O_ready(ready), .O_crc(crc), .O_len(len), .O_crc_v(crc_v),
    .I_crc_ready(crc_ready), .O_crc_ok(crc_ok), .O_frame_err(frame_err)
  );

  crc_stream_engine #(
    .C_DWIDTH(8), .C_GEN_WIDTH(16), .C_GEN_SEQ(32'h00001021), .C_INIT(32'h0000ffff),
    .C_XOR_OUT(32'h0), .C_IN_REFLECT(1'b0), .C_OUT_REFLECT(1'b0), .C_RESIDUE(32'h0),
    .C_LEN_WIDTH(16)
  ) dut8 (
    .I_clk(clk), .I_rst(rst), .I_data(d8_data), .I_data_v(d8_v), .I_sof(d8_sof), .I_eof(d8_eof),
    .I_keep(d8_keep), .O_ready(d8_ready), .O_crc(d8_crc), .O_len(d8_len), .O_crc_v(d8_crc_v),
    .I_crc_ready(d8_crc_ready), .O_crc_ok(d8_ok), .O_frame_err(d8_err)
  );

  typedef struct {
    logic [31:0] crc;
    logic [15:0] len;
    logic        ok;
  } exp_t;

  exp_t       exp_q[$];
  exp_t       exp8_q[$];
  logic [7:0] fr_q[$];
  logic [7:0] fr8_q[$];
  int vectors = 0;
  int miscompares = 0;

  // Reference CRC-32 in the reflected (right-shifting) form; returns the pre-XOR register.
  function automatic logic [31:0] model_crc32_reg();
    logic [31:0] r;
    r = 32'hffffffff;
    foreach (fr_q[i]) begin
      r = r ^ {24'h0, fr_q[i]};
      for (int b = 0; b < 8; b++) r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    end
    return r;
  endfunction

  function automatic logic [15:0] model_ccitt();
    logic [15:0] r;
    r = 16'hffff;
    foreach (fr8_q[i]) begin
      r = r ^ {fr8_q[i], 8'h00};
      for (int b = 0; b < 8; b++) r = r[15] ? ((r << 1) ^ 16'h1021) : (r << 1);
    end
    return r;
  endfunction

  task automatic push_expected();
    exp_t        e;
    logic [31:0] r;
    r     = model_crc32_reg();
    e.crc = r ^ 32'hffffffff;
    e.len = 16'(fr_q.size());
`ifdef CRC_CHECK_EN
    e.ok  = (r == 32'hDEBB20E3);
`else
    e.ok  = 1'b0;
`endif
    exp_q.push_back(e);
  endtask

  task automatic drive_beat(input logic [31:0] d, input logic s, input logic e, input logic [3:0] k);
    int   t;
    logic run;
    data = d; sof = s; eof = e; keep = k; data_v = 1'b1;
    t = 0;
    while (ready !== 1'b1 && t < 50) begin
      @(posedge clk); #1; t++;
    end
    if (t == 50) begin
      vectors++; miscompares++;
      $display("FAIL beat_accept ready=%b required 1 within 50 cycles", ready);
    end
    @(posedge clk); #1;
    data_v = 1'b0;
    if (s) fr_q.delete();
    run = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (e && !k[i]) run = 1'b0;
      if (run) fr_q.push_back(d[8*i +: 8]);
    end
    if (e) push_expected();
  endtask

  task automatic collect(input string name);
    int   t;
    exp_t e;
    t = 0;
    while (crc_v !== 1'b1 && t < 50) begin
      @(posedge clk); #1; t++;
    end
    vectors++;
    if (t == 50 || exp_q.size() == 0) begin
      miscompares++;
      $display("FAIL %s result_valid crc_v=%b queued=%0d required 1 and >0", name, crc_v, exp_q.size());
    end else begin
      e = exp_q.pop_front();
      if (crc !== e.crc) begin
        miscompares++;
        $display("FAIL %s crc got %h required %h", name, crc, e.crc);
      end
      vectors++;
      if (len !== e.len) begin
        miscompares++;
        $display("FAIL %s len got %0d required %0d", name, len, e.len);
      end
      vectors++;
      if (crc_ok !== e.ok) begin
        miscompares++;
        $display("FAIL %s crc_ok got %b required %b", name, crc_ok, e.ok);
      end
    end
    crc_ready = 1'b1;
    @(posedge clk); #1;
    crc_ready = 1'b0;
    vectors++;
    if ({crc_v, ready} !== 2'b01) begin
      miscompares++;
      $display("FAIL %s release crc_v,ready got %b required 01", name, {crc_v, ready});
    end
  endtask

  task automatic drive8(input logic [7:0] d, input logic s, input logic e);
    int t;
    d8_data = d; d8_sof = s; d8_eof = e; d8_keep = 1'b1; d8_v = 1'b1;
    t = 0;
    while (d8_ready !== 1'b1 && t < 50) begin
      @(posedge clk); #1; t++;
    end
    if (t == 50) begin
      vectors++; miscompares++;
      $display("FAIL beat8_accept ready=%b required 1 within 50 cycles", d8_ready);
    end
    @(posedge clk); #1;
    d8_v = 1'b0;
    if (s) fr8_q.delete();
    fr8_q.push_back(d);
  endtask

  task automatic collect8(input string name);
    int   t;
    exp_t e;
    t = 0;
    while (d8_crc_v !== 1'b1 && t < 50) begin
      @(posedge clk); #1; t++;
    end
    vectors++;
    if (t == 50 || exp8_q.size() == 0) begin
      miscompares++;
      $display("FAIL %s result_valid crc_v=%b queued=%0d required 1 and >0", name, d8_crc_v, exp8_q.size());
    end else begin
      e = exp8_q.pop_front();
      if (d8_crc !== e.crc[15:0]) begin
        miscompares++;
        $display("FAIL %s crc got %h required %h", name, d8_crc, e.crc[15:0]);
      end
      vectors++;
      if (d8_len !== e.len) begin
        miscompares++;
        $display("FAIL %s len got %0d required %0d", name, d8_len, e.len);
      end
    end
    d8_crc_ready = 1'b1;
    @(posedge clk); #1;
    d8_crc_ready = 1'b0;
  endtask

  task automatic send_123456789();
    drive_beat(32'h34333231, 1'b1, 1'b0, 4'hf);
    drive_beat(32'h38373635, 1'b0, 1'b0, 4'hf);
    drive_beat(32'h00000039, 1'b0, 1'b1, 4'b0001);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if ({ready, crc_v, crc, len, crc_ok, frame_err} !== {1'b1, 1'b0, 32'h0, 16'h0, 1'b0, 1'b0}) begin
      miscompares++;
      $display("FAIL reset rdy/v/crc/len/ok/err got %b/%b/%h/%h/%b/%b required 1/0/0/0/0/0",
               ready, crc_v, crc, len, crc_ok, frame_err);
    end
    vectors++;
    if ({d8_ready, d8_crc_v, d8_crc, d8_len} !== {1'b1, 1'b0, 16'h0, 16'h0}) begin
      miscompares++;
      $display("FAIL reset8 rdy/v/crc/len got %b/%b/%h/%h required 1/0/0/0", d8_ready, d8_crc_v, d8_crc, d8_len);
    end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_check_vector();
    drive_beat(32'h34333231, 1'b1, 1'b0, 4'hf);
    drive_beat(32'h38373635, 1'b0, 1'b0, 4'hf);
    vectors++;
    if (crc_v !== 1'b0) begin
      miscompares++;
      $display("FAIL early_valid crc_v got %b required 0", crc_v);
    end
    drive_beat(32'h00000039, 1'b0, 1'b1, 4'b0001);
    vectors++;
    if ({crc_v, ready, crc, len} !== {1'b1, 1'b0, 32'hCBF43926, 16'd9}) begin
      miscompares++;
      $display("FAIL check_vector v/rdy/crc/len got %b/%b/%h/%0d required 1/0/cbf43926/9", crc_v, ready, crc, len);
    end
    collect("check_vector");
  endtask

  task automatic test_hold_backpressure();
    send_123456789();
    data = 32'hdeadbeef; sof = 1'b1; eof = 1'b1; keep = 4'hf; data_v = 1'b1;
    for (int i = 0; i < 5; i++) begin
      vectors++;
      if ({crc_v, ready, crc, len} !== {1'b1, 1'b0, 32'hCBF43926, 16'd9}) begin
        miscompares++;
        $display("FAIL hold cycle %0d v/rdy/crc/len got %b/%b/%h/%0d required 1/0/cbf43926/9", i, crc_v, ready, crc, len);
      end
      @(posedge clk); #1;
    end
    data_v = 1'b0;
    collect("hold");
  endtask

  task automatic test_frame_err();
    data = 32'h11223344; sof = 1'b0; eof = 1'b1; keep = 4'hf; data_v = 1'b1;
    @(posedge clk); #1;
    data_v = 1'b0;
    vectors++;
    if ({frame_err, crc_v, ready} !== 3'b101) begin
      miscompares++;
      $display("FAIL idle_nosof err/v/rdy got %b required 101", {frame_err, crc_v, ready});
    end
    @(posedge clk); #1;
    vectors++;
    if ({frame_err, crc_v} !== 2'b00) begin
      miscompares++;
      $display("FAIL idle_nosof_pulse err/v got %b required 00", {frame_err, crc_v});
    end
    drive_beat(32'hcafef00d, 1'b1, 1'b0, 4'hf);
    vectors++;
    if (frame_err !== 1'b0) begin
      miscompares++;
      $display("FAIL clean_sof err got %b required 0", frame_err);
    end
    drive_beat(32'h01020304, 1'b0, 1'b0, 4'hf);
    drive_beat(32'ha5a55a5a, 1'b1, 1'b0, 4'hf);
    vectors++;
    if (frame_err !== 1'b1) begin
      miscompares++;
      $display("FAIL run_sof err got %b required 1", frame_err);
    end
    drive_beat(32'h0badc0de, 1'b0, 1'b1, 4'b0011);
    collect("restarted_frame");
  endtask

  task automatic test_residue();
`ifdef CRC_CHECK_EN
    drive_beat(32'h34333231, 1'b1, 1'b0, 4'hf);
    drive_beat(32'h38373635, 1'b0, 1'b0, 4'hf);
    drive_beat(32'hF4392639, 1'b0, 1'b0, 4'hf);
    drive_beat(32'h000000CB, 1'b0, 1'b1, 4'b0001);
    vectors++;
    if ({crc_ok, len} !== {1'b1, 16'd13}) begin
      miscompares++;
      $display("FAIL residue_good ok/len got %b/%0d required 1/13", crc_ok, len);
    end
    collect("residue_good");
    drive_beat(32'h34333230, 1'b1, 1'b0, 4'hf);
    drive_beat(32'h38373635, 1'b0, 1'b0, 4'hf);
    drive_beat(32'hF4392639, 1'b0, 1'b0, 4'hf);
    drive_beat(32'h000000CB, 1'b0, 1'b1, 4'b0001);
    vectors++;
    if (crc_ok !== 1'b0) begin
      miscompares++;
      $display("FAIL residue_bad ok got %b required 0", crc_ok);
    end
    collect("residue_bad");
`else
    drive_beat(32'h34333231, 1'b1, 1'b0, 4'hf);
    drive_beat(32'h38373635, 1'b0, 1'b0, 4'hf);
    drive_beat(32'hF4392639, 1'b0, 1'b0, 4'hf);
    drive_beat(32'h000000CB, 1'b0, 1'b1, 4'b0001);
    collect("residue_disabled");
`endif
  endtask

  task automatic test_reset_mid_frame();
    drive_beat(32'h55aa55aa, 1'b1, 1'b0, 4'hf);
    rst = 1'b1;
    data = 32'h12345678; sof = 1'b1; eof = 1'b1; keep = 4'hf; data_v = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; data_v = 1'b0;
    fr_q.delete();
    vectors++;
    if ({ready, crc_v, crc, len, crc_ok, frame_err} !== {1'b1, 1'b0, 32'h0, 16'h0, 1'b0, 1'b0}) begin
      miscompares++;
      $display("FAIL mid_reset rdy/v/crc/len/ok/err got %b/%b/%h/%h/%b/%b required 1/0/0/0/0/0",
               ready, crc_v, crc, len, crc_ok, frame_err);
    end
    @(posedge clk); #1;
    vectors++;
    if (crc_v !== 1'b0) begin
      miscompares++;
      $display("FAIL mid_reset_quiet crc_v got %b required 0", crc_v);
    end
    send_123456789();
    collect("after_reset");
  endtask

  task automatic test_back_to_back();
    logic [3:0] kp [7];
    int         nb;
    kp = '{4'b0000, 4'b0001, 4'b0011, 4'b0111, 4'b1111, 4'b0101, 4'b1011};
    for (int f = 0; f < 14; f++) begin
      nb = $urandom_range(1, 4);
      for (int b = 0; b < nb; b++)
        drive_beat($urandom, b == 0, b == nb - 1, kp[f % 7]);
      collect("back_to_back");
    end
  endtask

  task automatic test_ccitt8();
    exp_t       e;
    logic [7:0] s [9];
    int         n;
    s = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    for (int i = 0; i < 9; i++) drive8(s[i], i == 0, i == 8);
    e.crc = 32'h000029B1; e.len = 16'd9; e.ok = 1'b0;
    exp8_q.push_back(e);
    collect8("ccitt_check");
    n = $urandom_range(1, 6);
    for (int i = 0; i < n; i++) drive8(8'($urandom), i == 0, i == n - 1);
    e.crc = {16'h0, model_ccitt()}; e.len = 16'(n);
    exp8_q.push_back(e);
    collect8("ccitt_random");
  endtask

  initial begin
    test_reset();
    test_check_vector();
    test_hold_backpressure();
    test_frame_err();
    test_residue();
    test_reset_mid_frame();
    test_back_to_back();
    test_ccitt8();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
